// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared definitions for the boot-image loader: FSM state
//               encodings, frame header size and the default ROM capacity.
// Revision    : 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

  // Largest image (in 32-bit words) the instruction ROM can hold by default.
  localparam int ROM_COL_MAX = 64;

  // The frame header is a little-endian 16-bit word count.
  localparam int HDR_BYTES = 2;

  // Loader states, explicitly encoded.
  typedef enum logic [2:0] {
    ST_LEN_LO = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_DATA   = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  // The loader takes bytes only while it is still parsing a frame.
  function automatic logic state_accepts(input state_e s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
  endfunction

endpackage : prog_loader_pkg
`default_nettype wire

// File: rtl/prog_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader_if
// Description : Byte-stream input, ROM write port and status bundle of the
//               boot-image loader. The master side feeds bytes and watches
//               the ROM/status outputs; the slave side is the loader itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface prog_loader_if #(
  parameter int ADDR_W = 8
) ();

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              start;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [15:0]       words_written;

  modport master (
    output in_data, in_valid, start,
    input  in_ready, mem_we, mem_addr, mem_wdata,
    input  cpu_hold, done, err, words_written
  );

  modport slave (
    input  in_data, in_valid, start,
    output in_ready, mem_we, mem_addr, mem_wdata,
    output cpu_hold, done, err, words_written
  );

endinterface : prog_loader_if
`default_nettype wire

// File: rtl/prog_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : word_packer
// Description : Assembles little-endian 32-bit words from an accepted byte
//               stream. Emits a one-cycle word_valid pulse, registered, the
//               cycle after the fourth byte of a word is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module word_packer (
  input  wire logic        CLK,
  input  wire logic        reset,      // synchronous, active-low
  input  wire logic        clr,        // drop any partial word
  input  wire logic        accept,     // byte_in is consumed this cycle
  input  wire logic [7:0]  byte_in,
  output logic             last_slot,  // next accepted byte completes a word
  output logic             word_valid,
  output logic [31:0]      word
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q,   cnt_d;
  logic        word_valid_q, word_valid_d;
  logic [31:0] word_q,  word_d;

  // Next-state: bytes enter at the top so the first byte ends in bits 7:0.
  always_comb begin
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    word_valid_d = 1'b0;
    word_d       = word_q;
    if (clr) begin
      shift_d = 24'h0;
      cnt_d   = 2'd0;
    end else if (accept) begin
      if (cnt_q == 2'd3) begin
        word_d       = {byte_in, shift_q};
        word_valid_d = 1'b1;
        shift_d      = 24'h0;
        cnt_d        = 2'd0;
      end else begin
        shift_d = {byte_in, shift_q[23:8]};
        cnt_d   = cnt_q + 2'd1;
      end
    end
  end

  // State registers; reset also kills a pending write pulse.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      shift_q      <= 24'h0;
      cnt_q        <= 2'd0;
      word_valid_q <= 1'b0;
      word_q       <= 32'h0;
    end else begin
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      word_valid_q <= word_valid_d;
      word_q       <= word_d;
    end
  end

  assign last_slot  = (cnt_q == 2'd3);
  assign word_valid = word_valid_q;
  assign word       = word_q;

endmodule : word_packer
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Boot-image loader. Parses a frame of a 16-bit word count
//               followed by 4*N little-endian image bytes, writes each word
//               into instruction ROM and holds the CPU in reset until the
//               image is complete. Oversized images latch a sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  // Must not exceed 2**ADDR_W, otherwise ROM addresses would alias.
  parameter int MAX_WORDS = ROM_COL_MAX
) (
  input  wire logic    CLK,
  input  wire logic    reset,   // synchronous, active-low
  prog_loader_if.slave bus
);

  localparam logic [16:0] MAX_WORDS_C = 17'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       words_written_q, words_written_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              xfer;
  logic [15:0]       n_full;
  logic              pk_accept;
  logic              pk_clr;
  logic              pk_last_slot;
  logic              pk_word_valid;
  logic [31:0]       pk_word;

  assign xfer   = bus.in_valid && in_ready_q;
  assign n_full = {bus.in_data, len_q[7:0]};

  word_packer u_packer (
    .CLK        (CLK),
    .reset      (reset),
    .clr        (pk_clr),
    .accept     (pk_accept),
    .byte_in    (bus.in_data),
    .last_slot  (pk_last_slot),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  // Frame parser: next state, word bookkeeping and registered status outputs.
  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    words_written_d = words_written_q;
    mem_addr_d      = mem_addr_q;
    pk_accept       = 1'b0;
    pk_clr          = 1'b0;

    case (state_q)
      ST_LEN_LO: begin
        if (xfer) begin
          len_d   = {8'h00, bus.in_data};
          state_d = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          len_d = n_full;
          if (n_full == 16'h0)
            state_d = ST_DONE;
          else if ({1'b0, n_full} > MAX_WORDS_C)
            state_d = ST_ERR;
          else
            state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (xfer) begin
          pk_accept = 1'b1;
          if (pk_last_slot) begin
            // The word lands at the pre-increment count; the strobe itself
            // comes from the packer one cycle after this byte.
            mem_addr_d      = words_written_q[ADDR_W-1:0];
            words_written_d = words_written_q + 16'd1;
            if (words_written_q == len_q - 16'd1)
              state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (bus.start) begin
          state_d         = ST_LEN_LO;
          words_written_d = 16'h0;
          pk_clr          = 1'b1;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_LEN_LO;
      end
    endcase

    in_ready_d = state_accepts(state_d);
    cpu_hold_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
  end

  // Loader FSM and output registers.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state_q         <= ST_LEN_LO;
      len_q           <= 16'h0;
      words_written_q <= 16'h0;
      mem_addr_q      <= '0;
      in_ready_q      <= 1'b1;
      cpu_hold_q      <= 1'b1;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      words_written_q <= words_written_d;
      mem_addr_q      <= mem_addr_d;
      in_ready_q      <= in_ready_d;
      cpu_hold_q      <= cpu_hold_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.mem_we        = pk_word_valid;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = pk_word;
  assign bus.cpu_hold      = cpu_hold_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;
  assign bus.words_written = words_written_q;

endmodule : prog_loader
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Directed self-checking bench for prog_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  logic CLK;
  logic reset;
  int   checks;
  int   errors;

  logic [31:0] wa[$];
  logic [31:0] wd[$];

  prog_loader_if #(.ADDR_W(8)) bus ();

  prog_loader #(.ADDR_W(8), .MAX_WORDS(64)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Record every ROM write, sampled mid-cycle.
  always @(negedge CLK) begin
    if (bus.mem_we === 1'b1) begin
      wa.push_back(32'(bus.mem_addr));
      wd.push_back(bus.mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One byte offered for exactly one rising edge.
  task automatic send(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic chk_write(input string tag, input int idx,
                           input logic [31:0] a, input logic [31:0] d);
    if (idx < wa.size()) begin
      chk({tag, "_addr"}, wa[idx], a);
      chk({tag, "_data"}, wd[idx], d);
    end else begin
      chk({tag, "_missing"}, 32'(wa.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    logic [7:0] stream [12];
    checks = 0;
    errors = 0;
    reset = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_mem_we",   32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_wdata",    bus.mem_wdata, 32'd0);
    chk("rst_ww",       32'(bus.words_written), 32'd0);
    chk("rst_hold",     32'(bus.cpu_hold), 32'd1);
    chk("rst_done",     32'(bus.done), 32'd0);
    chk("rst_err",      32'(bus.err), 32'd0);
    reset = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Two-word image
    wa.delete(); wd.delete();
    send(8'h02); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    chk("f1_we0", 32'(bus.mem_we), 32'd1);
    chk("f1_hold_mid", 32'(bus.cpu_hold), 32'd1);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    chk("f1_we1",    32'(bus.mem_we), 32'd1);
    chk("f1_addr1",  32'(bus.mem_addr), 32'd1);
    chk("f1_data1",  bus.mem_wdata, 32'h0010_0093);
    chk("f1_ww",     32'(bus.words_written), 32'd2);
    chk("f1_done",   32'(bus.done), 32'd1);
    chk("f1_hold",   32'(bus.cpu_hold), 32'd0);
    chk("f1_ready",  32'(bus.in_ready), 32'd0);
    idle();
    chk("f1_we_off", 32'(bus.mem_we), 32'd0);
    chk("f1_nwr",    32'(wa.size()), 32'd2);
    chk_write("f1_w0", 0, 32'd0, 32'h0000_0013);
    chk_write("f1_w1", 1, 32'd1, 32'h0010_0093);

    // Empty image
    pulse_start();
    chk("f2_ready", 32'(bus.in_ready), 32'd1);
    chk("f2_ww",    32'(bus.words_written), 32'd0);
    chk("f2_done0", 32'(bus.done), 32'd0);
    wa.delete(); wd.delete();
    send(8'h00);
    chk("f2_done_early", 32'(bus.done), 32'd0);
    send(8'h00);
    chk("f2_done", 32'(bus.done), 32'd1);
    idle();
    chk("f2_nwr", 32'(wa.size()), 32'd0);

    // Re-armed single word
    pulse_start();
    wa.delete(); wd.delete();
    send(8'h01); send(8'h00);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("f3_ww",   32'(bus.words_written), 32'd1);
    chk("f3_done", 32'(bus.done), 32'd1);
    idle();
    chk("f3_nwr", 32'(wa.size()), 32'd1);
    chk_write("f3_w0", 0, 32'd0, 32'h0403_0201);

    // Three words with a bubble after every byte
    stream = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
               8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    pulse_start();
    wa.delete(); wd.delete();
    send(8'h03); idle(); send(8'h00); idle();
    for (int i = 0; i < 12; i++) begin
      send(stream[i]);
      chk($sformatf("f4_we_b%0d", i), 32'(bus.mem_we), ((i % 4) == 3) ? 32'd1 : 32'd0);
      idle();
      chk($sformatf("f4_we_gap%0d", i), 32'(bus.mem_we), 32'd0);
    end
    chk("f4_done", 32'(bus.done), 32'd1);
    chk("f4_ww",   32'(bus.words_written), 32'd3);
    chk("f4_nwr",  32'(wa.size()), 32'd3);
    chk_write("f4_w0", 0, 32'd0, 32'h4433_2211);
    chk_write("f4_w1", 1, 32'd1, 32'h8877_6655);
    chk_write("f4_w2", 2, 32'd2, 32'hCCBB_AA99);

    // Oversized image: N = 65
    pulse_start();
    wa.delete(); wd.delete();
    send(8'h41); send(8'h00);
    chk("f5_err",   32'(bus.err), 32'd1);
    chk("f5_ready", 32'(bus.in_ready), 32'd0);
    chk("f5_hold",  32'(bus.cpu_hold), 32'd1);
    chk("f5_done",  32'(bus.done), 32'd0);
    pulse_start();
    chk("f5_err_sticky",  32'(bus.err), 32'd1);
    chk("f5_ready_stuck", 32'(bus.in_ready), 32'd0);
    chk("f5_nwr", 32'(wa.size()), 32'd0);
    reset = 1'b0;
    @(posedge CLK);
    #1;
    reset = 1'b1;
    chk("f5_rst_err",   32'(bus.err), 32'd0);
    chk("f5_rst_ready", 32'(bus.in_ready), 32'd1);

    // Reset mid-word, then a clean frame
    wa.delete(); wd.delete();
    send(8'h01); send(8'h00); send(8'hAA); send(8'hBB);
    reset = 1'b0;
    @(posedge CLK);
    #1;
    chk("f6_rst_we", 32'(bus.mem_we), 32'd0);
    chk("f6_rst_ww", 32'(bus.words_written), 32'd0);
    reset = 1'b1;
    send(8'h01); send(8'h00);
    send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
    chk("f6_done", 32'(bus.done), 32'd1);
    idle();
    chk("f6_nwr", 32'(wa.size()), 32'd1);
    chk_write("f6_w0", 0, 32'd0, 32'hDEAD_BEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_prog_loader
`default_nettype wire
